// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//
// Memory-stage data-bus controller. Accepts one load/store from the memory
// stage, drives it on the data bus as a single registered request, stalls
// the pipeline until the response arrives and returns sign/zero-extended
// load data for writeback.
//
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   in_valid          : memory-stage instruction is a valid load/store
//   in_is_write       : 1 = store, 0 = load
//   in_addr[63:0]     : byte address
//   in_msize[2:0]     : access size (0:1B 1:2B 2:4B 3:8B)
//   in_unsigned       : loads zero-extend when 1, sign-extend when 0
//   in_wd[63:0]       : lane-aligned store data
//   in_strobe[7:0]    : byte strobe
//   flush             : kill the current memory-stage instruction
//   dreq_*            : registered bus request (valid/addr/size/strobe/data)
//   dresp_addr_ok     : request accepted by the bus
//   dresp_data_ok     : data phase complete
//   dresp_data[63:0]  : lane-aligned read data
//   stall             : hold all upstream stages
//   misalign          : combinational misaligned-access flag
//   done              : one-cycle completion pulse
//   rdata[63:0]       : extended load result, valid while done is high
// ---------------------------------------------------------------------------
module mem_access_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_is_write,
  input  logic [63:0] in_addr,
  input  logic [2:0]  in_msize,
  input  logic        in_unsigned,
  input  logic [63:0] in_wd,
  input  logic [7:0]  in_strobe,
  input  logic        flush,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data,
  output logic        stall,
  output logic        misalign,
  output logic        done,
  output logic [63:0] rdata
);

  localparam logic [2:0] MSIZE1 = 3'd0;
  localparam logic [2:0] MSIZE2 = 3'd1;
  localparam logic [2:0] MSIZE4 = 3'd2;
  localparam logic [2:0] MSIZE8 = 3'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        kill_q, kill_d;
  logic [63:0] req_addr_q, req_addr_d;
  logic [2:0]  req_size_q, req_size_d;
  logic        req_write_q, req_write_d;
  logic        req_unsigned_q, req_unsigned_d;
  logic [63:0] req_data_q, req_data_d;
  logic [7:0]  req_strobe_q, req_strobe_d;
  logic [63:0] rdata_q, rdata_d;

  logic        misalign_raw;
  logic        accept;
  logic        data_phase_end;
  logic [63:0] load_shifted;

  // Extend the low bytes of a right-justified load word to 64 bits.
  function automatic logic [63:0] extend_load(input logic [63:0] d,
                                              input logic [2:0]  size,
                                              input logic        uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    logic signed [63:0] r;
    b = d[7:0];
    h = d[15:0];
    w = d[31:0];
    r = d;
    case (size)
      MSIZE1:  if (uns) r = {56'd0, d[7:0]};  else r = b;
      MSIZE2:  if (uns) r = {48'd0, d[15:0]}; else r = h;
      MSIZE4:  if (uns) r = {32'd0, d[31:0]}; else r = w;
      default: r = d;
    endcase
    return r;
  endfunction

  // Alignment check on the incoming op; undefined size codes never fault.
  always_comb begin
    misalign_raw = 1'b0;
    case (in_msize)
      MSIZE2:  misalign_raw = in_addr[0];
      MSIZE4:  misalign_raw = |in_addr[1:0];
      MSIZE8:  misalign_raw = |in_addr[2:0];
      default: misalign_raw = 1'b0;
    endcase
  end

  assign misalign = in_valid & misalign_raw;
  assign accept   = (state_q == S_IDLE) & in_valid & ~misalign_raw & ~flush;

  // A data phase only ends in REQ together with addr_ok; a lone data_ok
  // in REQ is a protocol violation and is ignored.
  assign data_phase_end = ((state_q == S_REQ) & dresp_addr_ok & dresp_data_ok) |
                          ((state_q == S_WAIT) & dresp_data_ok);

  assign load_shifted = dresp_data >> {req_addr_q[2:0], 3'b000};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_REQ;
      S_REQ: begin
        if (dresp_addr_ok & dresp_data_ok) state_d = S_DONE;
        else if (dresp_addr_ok)            state_d = S_WAIT;
      end
      S_WAIT: if (dresp_data_ok) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request registers, kill flag and load result
  always_comb begin
    req_addr_d     = req_addr_q;
    req_size_d     = req_size_q;
    req_write_d    = req_write_q;
    req_unsigned_d = req_unsigned_q;
    req_data_d     = req_data_q;
    req_strobe_d   = req_strobe_q;
    kill_d         = kill_q;
    rdata_d        = rdata_q;

    if (accept) begin
      req_addr_d     = in_addr;
      req_size_d     = in_msize;
      req_write_d    = in_is_write;
      req_unsigned_d = in_unsigned;
      // Loads carry no write data or strobe onto the bus.
      req_data_d     = in_is_write ? in_wd : 64'd0;
      req_strobe_d   = in_is_write ? in_strobe : 8'd0;
      kill_d         = 1'b0;
    end

    // The bus transaction cannot be withdrawn, so a flush only marks the
    // op dead and the completion pulse is swallowed later.
    if (((state_q == S_REQ) | (state_q == S_WAIT)) & flush) begin
      kill_d = 1'b1;
    end

    if (data_phase_end) begin
      rdata_d = req_write_q ? 64'd0
                            : extend_load(load_shifted, req_size_q, req_unsigned_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_addr_q     <= 64'd0;
      req_size_q     <= 3'd0;
      req_write_q    <= 1'b0;
      req_unsigned_q <= 1'b0;
      req_data_q     <= 64'd0;
      req_strobe_q   <= 8'd0;
      kill_q         <= 1'b0;
      rdata_q        <= 64'd0;
    end else begin
      req_addr_q     <= req_addr_d;
      req_size_q     <= req_size_d;
      req_write_q    <= req_write_d;
      req_unsigned_q <= req_unsigned_d;
      req_data_q     <= req_data_d;
      req_strobe_q   <= req_strobe_d;
      kill_q         <= kill_d;
      rdata_q        <= rdata_d;
    end
  end

  // Output logic
  always_comb begin
    dreq_valid  = (state_q == S_REQ);
    dreq_addr   = req_addr_q;
    dreq_size   = req_size_q;
    dreq_strobe = req_strobe_q;
    dreq_data   = req_data_q;
    stall       = accept | (state_q == S_REQ) | (state_q == S_WAIT);
    done        = (state_q == S_DONE) & ~kill_q;
    rdata       = rdata_q;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_is_write;
  logic [63:0] in_addr;
  logic [2:0]  in_msize;
  logic        in_unsigned;
  logic [63:0] in_wd;
  logic [7:0]  in_strobe;
  logic        flush;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        stall;
  logic        misalign;
  logic        done;
  logic [63:0] rdata;

  int n_chk = 0;
  int n_err = 0;

  mem_access_ctrl dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_is_write(in_is_write), .in_addr(in_addr),
    .in_msize(in_msize), .in_unsigned(in_unsigned), .in_wd(in_wd),
    .in_strobe(in_strobe), .flush(flush),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
    .dresp_data(dresp_data),
    .stall(stall), .misalign(misalign), .done(done), .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic quiet();
    in_valid = 0; in_is_write = 0; in_addr = 0; in_msize = 0; in_unsigned = 0;
    in_wd = 0; in_strobe = 0; flush = 0;
    dresp_addr_ok = 0; dresp_data_ok = 0; dresp_data = 0;
  endtask

  task automatic issue(input logic wr, input logic [63:0] a, input logic [2:0] sz,
                       input logic uns, input logic [63:0] wd, input logic [7:0] st);
    in_valid = 1; in_is_write = wr; in_addr = a; in_msize = sz;
    in_unsigned = uns; in_wd = wd; in_strobe = st;
  endtask

  // Single-cycle load: accept, respond at N+1, check result at N+2.
  task automatic do_load(input string tag, input logic [63:0] a, input logic [2:0] sz,
                         input logic uns, input logic [63:0] rd, input logic [63:0] exp);
    issue(0, a, sz, uns, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
    settle();
    tick();
    in_valid = 0;
    dresp_addr_ok = 1; dresp_data_ok = 1; dresp_data = rd;
    settle();
    chk({tag, "_strobe"}, {56'd0, dreq_strobe}, 64'd0);
    chk({tag, "_wdata"}, dreq_data, 64'd0);
    tick();
    dresp_addr_ok = 0; dresp_data_ok = 0; dresp_data = 0;
    settle();
    chk({tag, "_done"}, {63'd0, done}, 64'd1);
    chk({tag, "_rdata"}, rdata, exp);
    tick();
  endtask

  initial begin
    quiet();
    reset = 1;
    #12;
    chk("rst_dreq_valid", {63'd0, dreq_valid}, 64'd0);
    chk("rst_dreq_addr", dreq_addr, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    reset = 0;
    tick();

    // SB at 0x1003
    issue(1, 64'h1003, 3'd0, 0, 64'hAB00_0000, 8'h08);
    settle();
    chk("sb_stall_n", {63'd0, stall}, 64'd1);
    chk("sb_dvalid_n", {63'd0, dreq_valid}, 64'd0);
    tick();
    in_valid = 0;
    dresp_addr_ok = 1; dresp_data_ok = 1;
    settle();
    chk("sb_dvalid", {63'd0, dreq_valid}, 64'd1);
    chk("sb_addr", dreq_addr, 64'h1003);
    chk("sb_size", {61'd0, dreq_size}, 64'd0);
    chk("sb_strobe", {56'd0, dreq_strobe}, 64'h08);
    chk("sb_data", dreq_data, 64'hAB00_0000);
    chk("sb_stall_n1", {63'd0, stall}, 64'd1);
    tick();
    dresp_addr_ok = 0; dresp_data_ok = 0;
    settle();
    chk("sb_done", {63'd0, done}, 64'd1);
    chk("sb_stall_n2", {63'd0, stall}, 64'd0);
    tick();
    chk("sb_done_one", {63'd0, done}, 64'd0);
    chk("sb_dvalid_idle", {63'd0, dreq_valid}, 64'd0);

    // Load extraction
    do_load("lb",  64'h2005, 3'd0, 0, 64'h0000_8000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    do_load("lbu", 64'h2005, 3'd0, 1, 64'h0000_8000_0000_0000, 64'h0000_0000_0000_0080);
    do_load("lw",  64'h2004, 3'd2, 0, 64'h7FFF_FFFF_0000_0000, 64'h0000_0000_7FFF_FFFF);
    do_load("lh",  64'h2006, 3'd1, 0, 64'hBEEF_0000_0000_0000, 64'hFFFF_FFFF_FFFF_BEEF);
    do_load("lhu", 64'h2006, 3'd1, 1, 64'hBEEF_0000_0000_0000, 64'h0000_0000_0000_BEEF);
    do_load("lwu", 64'h2000, 3'd2, 1, 64'h1234_5678_8765_4321, 64'h0000_0000_8765_4321);

    // Split handshake: addr_ok at N+1, data_ok at N+4
    issue(0, 64'h3000, 3'd3, 0, 64'd0, 8'd0);
    settle();
    chk("split_stall_n", {63'd0, stall}, 64'd1);
    tick();
    in_valid = 0;
    dresp_addr_ok = 1;
    settle();
    chk("split_dvalid_n1", {63'd0, dreq_valid}, 64'd1);
    tick();
    dresp_addr_ok = 0;
    settle();
    chk("split_dvalid_n2", {63'd0, dreq_valid}, 64'd0);
    chk("split_stall_n2", {63'd0, stall}, 64'd1);
    tick();
    settle();
    chk("split_stall_n3", {63'd0, stall}, 64'd1);
    chk("split_done_n3", {63'd0, done}, 64'd0);
    tick();
    dresp_data_ok = 1; dresp_data = 64'h1122_3344_5566_7788;
    settle();
    chk("split_stall_n4", {63'd0, stall}, 64'd1);
    tick();
    dresp_data_ok = 0; dresp_data = 0;
    settle();
    chk("split_done_n5", {63'd0, done}, 64'd1);
    chk("split_rdata", rdata, 64'h1122_3344_5566_7788);
    tick();

    // addr_ok withheld 3 cycles; inputs change under a stalled request
    issue(1, 64'h4008, 3'd3, 0, 64'h0102_0304_0506_0708, 8'hFF);
    settle();
    tick();
    for (int i = 0; i < 3; i++) begin
      in_addr = 64'h9990 + 64'(i); in_wd = 64'hFFFF_0000 + 64'(i); in_strobe = 8'h0F;
      in_msize = 3'd0;
      settle();
      chk("hold_dvalid", {63'd0, dreq_valid}, 64'd1);
      chk("hold_addr", dreq_addr, 64'h4008);
      chk("hold_data", dreq_data, 64'h0102_0304_0506_0708);
      chk("hold_strobe", {56'd0, dreq_strobe}, 64'hFF);
      chk("hold_size", {61'd0, dreq_size}, 64'd3);
      tick();
    end
    in_valid = 0;
    dresp_addr_ok = 1; dresp_data_ok = 1;
    settle();
    chk("hold_addr_ok", dreq_addr, 64'h4008);
    tick();
    dresp_addr_ok = 0; dresp_data_ok = 0;
    settle();
    chk("hold_done", {63'd0, done}, 64'd1);
    chk("store_rdata_zero", rdata, 64'd0);
    tick();

    // Misaligned accesses never issue
    issue(0, 64'h1002, 3'd2, 0, 64'd0, 8'd0);
    settle();
    chk("mis_lw_flag", {63'd0, misalign}, 64'd1);
    chk("mis_lw_stall", {63'd0, stall}, 64'd0);
    tick();
    chk("mis_lw_dvalid", {63'd0, dreq_valid}, 64'd0);
    chk("mis_lw_done", {63'd0, done}, 64'd0);
    in_addr = 64'h1001; in_msize = 3'd1;
    settle();
    chk("mis_lh_flag", {63'd0, misalign}, 64'd1);
    in_addr = 64'h1004; in_msize = 3'd3;
    settle();
    chk("mis_ld_flag", {63'd0, misalign}, 64'd1);
    tick();
    chk("mis_ld_dvalid", {63'd0, dreq_valid}, 64'd0);
    // Aligned op with flush in IDLE: no flag, no stall, no request
    in_addr = 64'h1004; in_msize = 3'd2; flush = 1;
    settle();
    chk("flush_idle_mis", {63'd0, misalign}, 64'd0);
    chk("flush_idle_stall", {63'd0, stall}, 64'd0);
    tick();
    in_valid = 0; flush = 0;
    settle();
    chk("flush_idle_dvalid", {63'd0, dreq_valid}, 64'd0);
    tick();

    // Flush during WAIT
    issue(0, 64'h5000, 3'd3, 0, 64'd0, 8'd0);
    settle();
    tick();
    in_valid = 0;
    dresp_addr_ok = 1;
    settle();
    tick();
    dresp_addr_ok = 0; flush = 1;
    settle();
    chk("fw_stall_wait", {63'd0, stall}, 64'd1);
    tick();
    flush = 0; dresp_data_ok = 1; dresp_data = 64'h55;
    settle();
    chk("fw_stall_dok", {63'd0, stall}, 64'd1);
    tick();
    dresp_data_ok = 0; dresp_data = 0;
    settle();
    chk("fw_done_killed", {63'd0, done}, 64'd0);
    chk("fw_stall_done", {63'd0, stall}, 64'd0);
    tick();
    chk("fw_idle_dvalid", {63'd0, dreq_valid}, 64'd0);
    chk("fw_idle_stall", {63'd0, stall}, 64'd0);

    // Fresh op after a killed one completes normally
    do_load("post_kill", 64'h6001, 3'd0, 1, 64'h0000_0000_0000_7F00, 64'h7F);

    // Reset asserted in WAIT
    issue(1, 64'h7010, 3'd2, 0, 64'hCAFE_F00D_0000_0000, 8'hF0);
    settle();
    tick();
    in_valid = 0;
    dresp_addr_ok = 1;
    settle();
    tick();
    dresp_addr_ok = 0;
    settle();
    chk("rw_stall_wait", {63'd0, stall}, 64'd1);
    #1;
    reset = 1;
    #1;
    chk("rw_stall", {63'd0, stall}, 64'd0);
    chk("rw_dvalid", {63'd0, dreq_valid}, 64'd0);
    chk("rw_addr", dreq_addr, 64'd0);
    chk("rw_data", dreq_data, 64'd0);
    chk("rw_strobe", {56'd0, dreq_strobe}, 64'd0);
    chk("rw_done", {63'd0, done}, 64'd0);
    chk("rw_rdata", rdata, 64'd0);
    #1;
    reset = 0;
    tick();
    dresp_data_ok = 1;
    settle();
    chk("rw_idle_stall", {63'd0, stall}, 64'd0);
    tick();
    dresp_data_ok = 0;
    settle();
    chk("rw_idle_done", {63'd0, done}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
